// File: rtl/proc_ctrl_unit.sv
// Instruction-sequencing control unit: latches III_XXX_YYY from DIN and walks T0..T3.
// Optional macro PROC_EXT_OPS_EN adds opcode 100 (and Rx,Ry).
module proc_ctrl_unit #(
  parameter int OPC_W = 3,
  parameter int SEL_W = 3,
  parameter int IR_W  = OPC_W + 2*SEL_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic [IR_W-1:0]  DIN,
  output logic             IRin,
  output logic [SEL_W-1:0] Rin_code,
  output logic             Rin_en,
  output logic [SEL_W-1:0] Rout_code,
  output logic             Rout_en,
  output logic             DINout,
  output logic             Gout,
  output logic             Ain,
  output logic             Gin,
  output logic [1:0]       ALUop,
  output logic             Done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  typedef enum logic [OPC_W-1:0] {
    OP_MV  = OPC_W'(0),
    OP_MVI = OPC_W'(1),
    OP_ADD = OPC_W'(2),
    OP_SUB = OPC_W'(3),
    OP_AND = OPC_W'(4)
  } opc_t;

  tstep_t          r_state;
  logic [IR_W-1:0] r_ir;

  logic [OPC_W-1:0] w_opc;
  logic [SEL_W-1:0] w_x;
  logic [SEL_W-1:0] w_y;
  logic             w_alu_op;
  logic [1:0]       w_alu_sel;

  assign w_opc = r_ir[IR_W-1 -: OPC_W];
  assign w_x   = r_ir[2*SEL_W-1 -: SEL_W];
  assign w_y   = r_ir[SEL_W-1:0];

  // Three-step ALU instructions share one T1..T3 sequence; only ALUop differs.
  always_comb begin
    w_alu_op  = 1'b0;
    w_alu_sel = 2'b00;
    case (w_opc)
      OP_ADD: begin
        w_alu_op  = 1'b1;
        w_alu_sel = 2'b00;
      end
      OP_SUB: begin
        w_alu_op  = 1'b1;
        w_alu_sel = 2'b01;
      end
`ifdef PROC_EXT_OPS_EN
      OP_AND: begin
        w_alu_op  = 1'b1;
        w_alu_sel = 2'b10;
      end
`endif
      default: begin
        w_alu_op  = 1'b0;
        w_alu_sel = 2'b00;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        T0: begin
          if (Run) begin
            r_ir    <= DIN;
            r_state <= T1;
          end
        end
        T1:      r_state <= w_alu_op ? T2 : T0;
        T2:      r_state <= T3;
        T3:      r_state <= T0;
        default: r_state <= T0;
      endcase
    end
  end

  // Outputs are combinational; Reset gates them so an aborted instruction never shows Done.
  always_comb begin
    IRin      = 1'b0;
    Rin_code  = '0;
    Rin_en    = 1'b0;
    Rout_code = '0;
    Rout_en   = 1'b0;
    DINout    = 1'b0;
    Gout      = 1'b0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    ALUop     = 2'b00;
    Done      = 1'b0;
    if (!Reset) begin
      case (r_state)
        T0: IRin = Run;
        T1: begin
          if (w_opc == OP_MV) begin
            Rout_code = w_y;
            Rout_en   = 1'b1;
            Rin_code  = w_x;
            Rin_en    = 1'b1;
            Done      = 1'b1;
          end else if (w_opc == OP_MVI) begin
            DINout   = 1'b1;
            Rin_code = w_x;
            Rin_en   = 1'b1;
            Done     = 1'b1;
          end else if (w_alu_op) begin
            Rout_code = w_x;
            Rout_en   = 1'b1;
            Ain       = 1'b1;
          end else begin
            Done = 1'b1;
          end
        end
        T2: begin
          if (w_alu_op) begin
            Rout_code = w_y;
            Rout_en   = 1'b1;
            Gin       = 1'b1;
            ALUop     = w_alu_sel;
          end
        end
        T3: begin
          if (w_alu_op) begin
            Gout     = 1'b1;
            Rin_code = w_x;
            Rin_en   = 1'b1;
            Done     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_ctrl_unit.sv
// Directed bench for proc_ctrl_unit; outputs packed into one vector and compared per cycle.
module tb_proc_ctrl_unit;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Run;
  logic [8:0] DIN;
  logic       IRin;
  logic [2:0] Rin_code;
  logic       Rin_en;
  logic [2:0] Rout_code;
  logic       Rout_en;
  logic       DINout;
  logic       Gout;
  logic       Ain;
  logic       Gin;
  logic [1:0] ALUop;
  logic       Done;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  proc_ctrl_unit #(.OPC_W(3), .SEL_W(3)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
    .IRin(IRin), .Rin_code(Rin_code), .Rin_en(Rin_en),
    .Rout_code(Rout_code), .Rout_en(Rout_en),
    .DINout(DINout), .Gout(Gout), .Ain(Ain), .Gin(Gin),
    .ALUop(ALUop), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // {IRin, Rin_code, Rin_en, Rout_code, Rout_en, DINout, Gout, Ain, Gin, ALUop, Done}
  function automatic logic [15:0] pk(input logic irin, input logic [2:0] rc, input logic re,
                                     input logic [2:0] oc, input logic oe, input logic dout,
                                     input logic gout, input logic ain, input logic gin,
                                     input logic [1:0] alu, input logic done);
    return {irin, rc, re, oc, oe, dout, gout, ain, gin, alu, done};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    #2;
    check_eq(tag, pk(IRin, Rin_code, Rin_en, Rout_code, Rout_en, DINout, Gout, Ain, Gin, ALUop, Done), exp);
  endtask

  localparam logic [15:0] ZERO = 16'h0000;
  localparam logic [15:0] IRIN = 16'h8000;

  initial begin
    Reset = 1'b1; Run = 1'b1; DIN = 9'o001;
    chk("rst_pre", ZERO);
    tick; chk("rst_c1", ZERO);
    tick; chk("rst_c2", ZERO);
    tick; Reset = 1'b0; Run = 1'b0; chk("t0_idle", ZERO);

    // mv R3,R5
    Run = 1'b1; DIN = 9'o035; chk("mv_irin", IRIN);
    tick; Run = 1'b0;
    chk("mv_t1", pk(0, 3'd3, 1, 3'd5, 1, 0, 0, 0, 0, 2'b00, 1));
    tick; chk("mv_back_t0", ZERO);

    // mvi R6 with immediate 0x1A5 on DIN during T1; Run held to show it is ignored
    Run = 1'b1; DIN = 9'o160; chk("mvi_irin", IRIN);
    tick; DIN = 9'h1A5;
    chk("mvi_t1", pk(0, 3'd6, 1, 3'd0, 0, 1, 0, 0, 0, 2'b00, 1));
    tick; Run = 1'b0; chk("mvi_back_t0", ZERO);

    // sub R1,R2 with Run toggling
    Run = 1'b1; DIN = 9'o312; chk("sub_irin", IRIN);
    tick; DIN = 9'o000;
    chk("sub_t1", pk(0, 3'd0, 0, 3'd1, 1, 0, 0, 1, 0, 2'b00, 0));
    tick; Run = 1'b0;
    chk("sub_t2", pk(0, 3'd0, 0, 3'd2, 1, 0, 0, 0, 1, 2'b01, 0));
    tick; Run = 1'b1;
    chk("sub_t3", pk(0, 3'd1, 1, 3'd0, 0, 0, 1, 0, 0, 2'b00, 1));
    tick; Run = 1'b0; chk("sub_back_t0", ZERO);

    // add R2,R2 aborted by reset in T2
    Run = 1'b1; DIN = 9'o222; chk("add_irin", IRIN);
    tick; Run = 1'b0;
    chk("add_t1", pk(0, 3'd0, 0, 3'd2, 1, 0, 0, 1, 0, 2'b00, 0));
    tick; chk("add_t2", pk(0, 3'd0, 0, 3'd2, 1, 0, 0, 0, 1, 2'b00, 0));
    Reset = 1'b1; chk("add_rst_forced", ZERO);
    tick; Reset = 1'b0; chk("abort_t0", ZERO);
    tick; chk("abort_no_done", ZERO);

    // mv R7,R0 after abort
    Run = 1'b1; DIN = 9'o070; chk("mv2_irin", IRIN);
    tick; Run = 1'b0;
    chk("mv2_t1", pk(0, 3'd7, 1, 3'd0, 1, 0, 0, 0, 0, 2'b00, 1));
    tick; chk("mv2_back_t0", ZERO);

    // opcode 100, X=0, Y=1
    Run = 1'b1; DIN = 9'o401; chk("op4_irin", IRIN);
    tick; Run = 1'b0;
`ifdef PROC_EXT_OPS_EN
    chk("and_t1", pk(0, 3'd0, 0, 3'd0, 1, 0, 0, 1, 0, 2'b00, 0));
    tick; chk("and_t2", pk(0, 3'd0, 0, 3'd1, 1, 0, 0, 0, 1, 2'b10, 0));
    tick; chk("and_t3", pk(0, 3'd0, 1, 3'd0, 0, 0, 1, 0, 0, 2'b00, 1));
    tick; chk("and_back_t0", ZERO);
`else
    chk("nop4_t1", pk(0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 2'b00, 1));
    tick; chk("nop4_back_t0", ZERO);
    tick; chk("nop4_idle", ZERO);
`endif

    // opcode 111 is always a NOP
    Run = 1'b1; DIN = 9'o777; chk("op7_irin", IRIN);
    tick; Run = 1'b0;
    chk("nop7_t1", pk(0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 2'b00, 1));
    tick; chk("nop7_back_t0", ZERO);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
